// File: rtl/fifo_fwft_ctrl_pkg.sv
// Shared types and constants for the FWFT FIFO controller and its RAM.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  localparam string FIFO_VENDOR    = "generic";
  localparam string FIFO_MEM_MODEL = "fifo_mem_sp_rreg";

endpackage

// File: rtl/fifo_fwft_ctrl_if.sv
// Producer push strobe and consumer valid/ready stream of the FWFT FIFO.
interface fifo_fwft_ctrl_if #(
  parameter int DSIZE = 8
);
  logic             push;
  logic [DSIZE-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (output push, output dout_ready, input dout, input dout_valid);
  modport slave  (input push, input dout_ready, output dout, output dout_valid);
endinterface

// File: rtl/fifo_fwft_ctrl_skid2.sv
// Two-entry output buffer turning registered RAM reads into a FWFT stream.
//   state | meaning
//   EMPTY | no word held, dout_valid low
//   ONE   | head word in slot 0
//   TWO   | head in slot 0, next word in slot 1
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [DSIZE-1:0] i_load_data,
  input  logic             i_pop,
  output logic [DSIZE-1:0] o_dout,
  output logic             o_dout_valid,
  output logic [1:0]       o_count
);

  buf_state_t       r_state;
  buf_state_t       w_state_nxt;
  logic [DSIZE-1:0] r_slot0;
  logic [DSIZE-1:0] r_slot1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (i_load) w_state_nxt = ONE;
      ONE: begin
        if (i_load && !i_pop)      w_state_nxt = TWO;
        else if (!i_load && i_pop) w_state_nxt = EMPTY;
      end
      TWO:     if (i_pop && !i_load) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // On a simultaneous load and pop the older word always shifts toward slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else begin
      case (r_state)
        EMPTY: if (i_load) r_slot0 <= i_load_data;
        ONE: begin
          if (i_load && i_pop) r_slot0 <= i_load_data;
          else if (i_load)     r_slot1 <= i_load_data;
        end
        TWO: begin
          if (i_pop) begin
            r_slot0 <= r_slot1;
            if (i_load) r_slot1 <= i_load_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_dout       = r_slot0;
    o_dout_valid = (r_state != EMPTY);
    case (r_state)
      ONE:     o_count = 2'd1;
      TWO:     o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

endmodule

// File: rtl/fifo_fwft_ctrl.sv
// Pointer, flag and level engine for fifo_mem with a first-word-fall-through output.
module fifo_fwft_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst,
  fifo_fwft_ctrl_if.slave  s_if,
  input  logic             i_clear_err,
  output logic [ASIZE-1:0] o_mem_waddr,
  output logic             o_mem_wclken,
  output logic             o_mem_wfull,
  output logic [ASIZE-1:0] o_mem_raddr,
  output logic             o_mem_rclken,
  output logic             o_mem_rempty,
  input  logic [DSIZE-1:0] i_mem_rdata,
  output logic [ASIZE:0]   o_level,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam logic [ASIZE:0] INC1   = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] AF_THR = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] AE_THR = AE_LEVEL[ASIZE:0];

  logic [ASIZE:0]   r_wptr;
  logic [ASIZE:0]   r_rptr;
  logic [ASIZE:0]   r_level;
  logic [ASIZE:0]   w_level_nxt;
  logic             r_inflight;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_rempty;
  logic             w_wfull;
  logic             w_wr_acc;
  logic             w_pop;
  logic             w_rd_issue;
  logic             w_dout_valid;
  logic [DSIZE-1:0] w_dout;
  logic [1:0]       w_buf_count;
  logic [2:0]       w_occupancy;

  assign w_rempty = (r_wptr == r_rptr);
  assign w_wfull  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                    (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);
  assign w_wr_acc = s_if.push && !w_wfull;
  assign w_pop    = w_dout_valid && s_if.dout_ready;

  // A pop this cycle frees a buffer slot, which keeps the stream gap-free.
  assign w_occupancy = {1'b0, w_buf_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_issue  = !w_rempty && (w_occupancy < 3'd2);

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_acc && !w_pop)      w_level_nxt = r_level + INC1;
    else if (!w_wr_acc && w_pop) w_level_nxt = r_level - INC1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_inflight     <= 1'b0;
      r_level        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_acc)   r_wptr <= r_wptr + INC1;
      if (w_rd_issue) r_rptr <= r_rptr + INC1;
      r_inflight     <= w_rd_issue;
      r_level        <= w_level_nxt;
      r_almost_full  <= (w_level_nxt >= AF_THR);
      r_almost_empty <= (w_level_nxt <= AE_THR);

      if (s_if.push && w_wfull) r_overflow <= 1'b1;
      else if (i_clear_err)     r_overflow <= 1'b0;

      if (s_if.dout_ready && !w_dout_valid) r_underflow <= 1'b1;
      else if (i_clear_err)                 r_underflow <= 1'b0;
    end
  end

  fifo_skid2 #(
    .DSIZE(DSIZE)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_load      (r_inflight),
    .i_load_data (i_mem_rdata),
    .i_pop       (w_pop),
    .o_dout      (w_dout),
    .o_dout_valid(w_dout_valid),
    .o_count     (w_buf_count)
  );

  assign s_if.dout       = w_dout;
  assign s_if.dout_valid = w_dout_valid;

  assign o_mem_waddr    = r_wptr[ASIZE-1:0];
  assign o_mem_wclken   = s_if.push;
  assign o_mem_wfull    = w_wfull;
  assign o_mem_raddr    = r_rptr[ASIZE-1:0];
  assign o_mem_rclken   = w_rd_issue;
  assign o_mem_rempty   = w_rempty;
  assign o_level        = r_level;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_fwft_ctrl.sv
// Directed bench for fifo_fwft_ctrl at ASIZE=2 with a behavioural registered-read RAM.
module tb_fifo_fwft_ctrl;
  import fifo_pkg::*;

  localparam int DSIZE = 8;
  localparam int ASIZE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear_err;
  logic [DSIZE-1:0] din;
  logic [ASIZE-1:0] waddr, raddr;
  logic             wclken, wfull, rclken, rempty;
  logic [DSIZE-1:0] rdata;
  logic [ASIZE:0]   level;
  logic             af, ae, ov, un;
  logic [DSIZE-1:0] ram [0:(1<<ASIZE)-1];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_fwft_ctrl_if #(.DSIZE(DSIZE)) f_if ();

  fifo_fwft_ctrl #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_if          (f_if),
    .i_clear_err   (clear_err),
    .o_mem_waddr   (waddr),
    .o_mem_wclken  (wclken),
    .o_mem_wfull   (wfull),
    .o_mem_raddr   (raddr),
    .o_mem_rclken  (rclken),
    .o_mem_rempty  (rempty),
    .i_mem_rdata   (rdata),
    .o_level       (level),
    .o_almost_full (af),
    .o_almost_empty(ae),
    .o_overflow    (ov),
    .o_underflow   (un)
  );

  // behavioural fifo_mem: gated write, 1-cycle registered read
  always @(posedge clk) begin
    if (wclken && !wfull) ram[waddr] <= din;
    if (rclken && !rempty) rdata <= ram[raddr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    f_if.push = 1'b0; f_if.dout_ready = 1'b0; clear_err = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    f_if.push = 1'b0; f_if.dout_ready = 1'b0; clear_err = 1'b0; din = '0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #1;
    vectors++;
    if ({level, rempty, wfull, rclken} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_flags level/rempty/wfull/rclken got %0d/%b/%b/%b exp 0/1/0/0",
               level, rempty, wfull, rclken);
    end
    vectors++;
    if ({f_if.dout_valid, f_if.dout} !== {1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_out valid/dout got %b/%h exp 0/00", f_if.dout_valid, f_if.dout);
    end
    vectors++;
    if ({ae, af, ov, un, waddr, raddr} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_status ae/af/ov/un/waddr/raddr got %b/%b/%b/%b/%0d/%0d exp 1/0/0/0/0/0",
               ae, af, ov, un, waddr, raddr);
    end
    // mid-stream reset with three words held
    for (int i = 0; i < 3; i++) begin
      f_if.push = 1'b1; din = 8'(8'hA0 + i);
      step();
    end
    f_if.push = 1'b0;
    vectors++;
    if (level !== 3'd3) begin
      miscompares++;
      $display("FAIL midrst_pre level got %0d exp 3", level);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({level, f_if.dout_valid, rempty} !== {3'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_post level/valid/rempty got %0d/%b/%b exp 0/0/1",
               level, f_if.dout_valid, rempty);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill_overflow();
    int got;
    int guard;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      f_if.push = 1'b1; din = 8'(8'h10 + i);
      step();
      vectors++;
      if ({level, af, ae} !== {3'(i + 1), (i + 1) >= 2, (i + 1) <= 2}) begin
        miscompares++;
        $display("FAIL fill_level i=%0d level/af/ae got %0d/%b/%b exp %0d/%b/%b", i, level, af, ae,
                 i + 1, (i + 1) >= 2, (i + 1) <= 2);
      end
      if (i < 2) begin
        vectors++;
        if (f_if.dout_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_latency_early i=%0d valid got %b exp 0", i, f_if.dout_valid);
        end
      end else if (i == 2) begin
        vectors++;
        if ({f_if.dout_valid, f_if.dout} !== {1'b1, 8'h10}) begin
          miscompares++;
          $display("FAIL fill_first_word valid/dout got %b/%h exp 1/10", f_if.dout_valid, f_if.dout);
        end
      end
      vectors++;
      if (wfull !== (i == 5)) begin
        miscompares++;
        $display("FAIL fill_wfull i=%0d got %b exp %b", i, wfull, i == 5);
      end
    end
    din = 8'h16;
    step();
    f_if.push = 1'b0;
    vectors++;
    if ({ov, level, wfull} !== {1'b1, 3'd6, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow ov/level/wfull got %b/%0d/%b exp 1/6/1", ov, level, wfull);
    end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    vectors++;
    if (ov !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear got %b exp 0", ov);
    end
    got = 0; guard = 0;
    f_if.dout_ready = 1'b1;
    while (got < 6 && guard < 40) begin
      if (f_if.dout_valid) begin
        vectors++;
        if (f_if.dout !== 8'(8'h10 + got)) begin
          miscompares++;
          $display("FAIL fill_drain word %0d got %h exp %h", got, f_if.dout, 8'(8'h10 + got));
        end
        got++;
      end
      step();
      guard++;
    end
    f_if.dout_ready = 1'b0;
    vectors++;
    if (got != 6 || level !== 3'd0) begin
      miscompares++;
      $display("FAIL fill_drain_done words/level got %0d/%0d exp 6/0", got, level);
    end
  endtask

  task automatic test_stream();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      f_if.push = (c < 32); din = 8'(c); f_if.dout_ready = 1'b1;
      step();
      exp_v = (c >= 2 && c <= 33);
      vectors++;
      if (f_if.dout_valid !== exp_v) begin
        miscompares++;
        $display("FAIL stream_valid c=%0d got %b exp %b", c, f_if.dout_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (f_if.dout !== 8'(c - 2)) begin
          miscompares++;
          $display("FAIL stream_data c=%0d got %h exp %h", c, f_if.dout, 8'(c - 2));
        end
      end
      vectors++;
      if (level > 3'd3) begin
        miscompares++;
        $display("FAIL stream_level c=%0d got %0d exp <=3", c, level);
      end
    end
    f_if.push = 1'b0; f_if.dout_ready = 1'b0;
    vectors++;
    if (level !== 3'd0) begin
      miscompares++;
      $display("FAIL stream_end_level got %0d exp 0", level);
    end
  endtask

  task automatic test_wrap();
    int sent, rcvd, exp_level, guard;
    logic pop_now;
    do_reset();
    sent = 0; rcvd = 0; exp_level = 0; guard = 0;
    while (rcvd < 20 && guard < 400) begin
      f_if.push = (sent < 20) && (exp_level <= 2) && ($urandom_range(0, 1) == 1);
      din = 8'(8'h40 + sent);
      f_if.dout_ready = ($urandom_range(0, 1) == 1);
      #1;
      pop_now = f_if.dout_valid && f_if.dout_ready;
      if (pop_now) begin
        vectors++;
        if (f_if.dout !== 8'(8'h40 + rcvd)) begin
          miscompares++;
          $display("FAIL wrap_data word %0d got %h exp %h", rcvd, f_if.dout, 8'(8'h40 + rcvd));
        end
        rcvd++;
      end
      if (f_if.push) sent++;
      exp_level = exp_level + (f_if.push ? 1 : 0) - (pop_now ? 1 : 0);
      step();
      guard++;
      vectors++;
      if ({level, af, ae} !== {3'(exp_level), exp_level >= 2, exp_level <= 2}) begin
        miscompares++;
        $display("FAIL wrap_level cyc=%0d level/af/ae got %0d/%b/%b exp %0d/%b/%b", guard, level, af,
                 ae, exp_level, exp_level >= 2, exp_level <= 2);
      end
    end
    f_if.push = 1'b0; f_if.dout_ready = 1'b0;
    vectors++;
    if (rcvd != 20) begin
      miscompares++;
      $display("FAIL wrap_timeout words got %0d exp 20", rcvd);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    f_if.dout_ready = 1'b1;
    step();
    vectors++;
    if ({un, waddr, raddr, rempty, level} !== {1'b1, 2'd0, 2'd0, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL underflow_set un/waddr/raddr/rempty/level got %b/%0d/%0d/%b/%0d exp 1/0/0/1/0",
               un, waddr, raddr, rempty, level);
    end
    f_if.dout_ready = 1'b0; clear_err = 1'b1;
    step();
    vectors++;
    if (un !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_clear got %b exp 0", un);
    end
    f_if.dout_ready = 1'b1;
    step();
    vectors++;
    if (un !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_clear_collide got %b exp 1", un);
    end
    f_if.dout_ready = 1'b0; clear_err = 1'b0;
  endtask

  task automatic test_back_to_back();
    int got;
    int guard;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      f_if.push = 1'b1; din = 8'(8'h20 + i);
      step();
    end
    // RAM full, buffer TWO with 0x20/0x21: pop and push in the same cycle
    din = 8'h26; f_if.dout_ready = 1'b1;
    vectors++;
    if ({wfull, f_if.dout_valid, f_if.dout} !== {1'b1, 1'b1, 8'h20}) begin
      miscompares++;
      $display("FAIL b2b_pre wfull/valid/dout got %b/%b/%h exp 1/1/20", wfull, f_if.dout_valid,
               f_if.dout);
    end
    step();
    f_if.dout_ready = 1'b0;
    vectors++;
    if ({f_if.dout, wfull, level, ov} !== {8'h21, 1'b0, 3'd5, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_pop dout/wfull/level/ov got %h/%b/%0d/%b exp 21/0/5/1", f_if.dout, wfull,
               level, ov);
    end
    step();
    f_if.push = 1'b0;
    vectors++;
    if ({wfull, level} !== {1'b1, 3'd6}) begin
      miscompares++;
      $display("FAIL b2b_retry wfull/level got %b/%0d exp 1/6", wfull, level);
    end
    got = 0; guard = 0;
    f_if.dout_ready = 1'b1;
    while (got < 6 && guard < 40) begin
      if (f_if.dout_valid) begin
        vectors++;
        if (f_if.dout !== 8'(8'h21 + got)) begin
          miscompares++;
          $display("FAIL b2b_drain word %0d got %h exp %h", got, f_if.dout, 8'(8'h21 + got));
        end
        got++;
      end
      step();
      guard++;
    end
    f_if.dout_ready = 1'b0;
    vectors++;
    if (got != 6 || level !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_done words/level got %0d/%0d exp 6/0", got, level);
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_stream();
    test_wrap();
    test_underflow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
